pe_mp_acc: RTL and testbench
============================

Name: pe_mp_acc

Overview:
- Next-generation precision-configurable processing element for the systolic array.
- Supports two modes, selectable per beat:
  - 16-bit mode: one signed 16x16 MAC.
  - 8-bit mode: two packed 8-bit activation lanes sharing one signed 8-bit weight.
- Adds a valid-qualified 2-stage pipeline, an optional internal accumulator (output-stationary use), per-lane saturation and sticky overflow flags.
- Sits in the PE grid between the activation/weight feeds and the partial-sum chain.

Parameters:
- ACT_WIDTH, 16, packed activation width; must equal 8*LANES.
- WGT_WIDTH, 16, weight width; the 8-bit mode uses b[7:0].
- PE_OUT_WIDTH, 48, accumulator width; must be even; lane width LW = PE_OUT_WIDTH/2.
- LANES, 2, number of 8-bit lanes; fixed at 2 in this generation.
- SAT_EN, 1, 1 = saturate on overflow, 0 = wrap (two's complement).

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, input beat valid.
- mode_8b, input, 1, 0 = 16-bit mode, 1 = 8-bit packed mode; sampled with the beat.
- act_signed, input, 1, 8-bit mode only: 1 = activation lanes signed, 0 = unsigned.
- a, input, ACT_WIDTH, activations; lane i = a[8i+7:8i].
- b, input, WGT_WIDTH, weight, always signed.
- c, input, PE_OUT_WIDTH, incoming partial sum.
- c_sel, input, 1, 1 = addend is c; 0 = addend is the internal accumulator (out register).
- acc_clear, input, 1, with in_valid: addend forced to 0 and ovf cleared for this beat.
- out, output, PE_OUT_WIDTH, result / accumulator.
- out_valid, output, 1, out updated this cycle.
- ovf, output, 2, sticky overflow flags; [0] = lane0 or 16-bit mode, [1] = lane1.

Behaviour:
- Reset (reset=0, asynchronous): out=0, out_valid=0, ovf=0, all stage-1 registers and stage-1 valid cleared.
  - A beat in flight when reset asserts is discarded; no out_valid follows release.
- Stage 1, on in_valid: register the products and the control bits mode_8b, c_sel and acc_clear.
  - c is also registered in stage 1 so that addend timing is aligned.
- Stage 2: add and saturate; out and out_valid update.
  - Latency is 2 cycles from in_valid to out_valid.
  - Throughput is 1 beat per cycle, including back-to-back internal accumulation (the feedback path is out itself).
- No valid beat at stage 2: out and ovf hold; out_valid=0.
- 16-bit mode arithmetic:
  - P = signed(a) * signed(b), 32 bits, sign-extended to PE_OUT_WIDTH.
  - Sum = P + addend at full width.
  - On signed overflow: SAT_EN=1 clamps to 0x7FFF..F / 0x800..0; ovf[0] set.
- 8-bit mode arithmetic:
  - Lane product P_i = ext(a_i, act_signed) * signed(b[7:0]), a 17-bit signed value sign-extended to LW.
  - Addend lane i = addend[LW*(i+1)-1 : LW*i].
  - No carry crosses the lane boundary.
  - Each lane saturates independently to the signed LW-bit range and sets ovf[i] on overflow.
- Mode may change every beat; each beat is computed in its own latched mode.
- Mixing modes on internal accumulation without acc_clear is legal: the bits are reinterpreted and no error is flagged.
- acc_clear:
  - Forces the addend to 0 for that beat only.
  - Clears both ovf bits, then ORs in any overflow from that beat.
- ovf is sticky until an acc_clear beat or reset.
- in_valid=0 ignores all other inputs.

Decomposition:
- Shared package pe_pkg holds:
  - Lane width function LW = PE_OUT_WIDTH/2.
  - Saturation max/min constants per width.
  - Mode encoding constants (MODE_16B=0, MODE_8B=1).
- One sub-module, pe_sat_add:
  - Parametrised width W and SAT_EN.
  - Inputs: two signed W-bit operands. Outputs: W-bit result and an overflow bit.
  - Instanced once at PE_OUT_WIDTH for the 16-bit path and twice at LW for the lanes; stage 2 muxes between them by the latched mode.

Test Plan:
- 16-bit mode, a=16'h0003, b=16'hFFFE, c=48'd10, c_sel=1 -> out=48'd4 two cycles later, out_valid pulses once, ovf=0.
- 8-bit unsigned mode, a=16'hFF02, b=16'h0081, c=0, act_signed=0 -> out=48'hFF817F_FFFF02.
  - Same beat with act_signed=1 -> out=48'h00007F_FFFF02.
- 8-bit lane isolation, c=48'h000005_7FFFFF, a=16'h0101, b=1, SAT_EN=1 -> out=48'h000006_7FFFFF, ovf=2'b01.
  - With SAT_EN=0 -> out=48'h000006_800000, ovf=2'b01.
- Internal accumulation, c_sel=0, 16-bit mode, a=100, b=3, acc_clear on the first of 4 beats with a 2-cycle in_valid gap after beat 2:
  - out = 300, 600, 900, 1200.
  - out holds 600 during the gap; out_valid asserts exactly 4 times.
- Back-to-back mode switch: beat0 16-bit mode, a=16'h0102, b=2; beat1 8-bit mode, same a and b; c=0, c_sel=1:
  - Consecutive outputs 48'd516 then 48'h000002_000004.
- Reset drop with one beat in stage 1 and out=48'd77 -> out=0, out_valid=0 and ovf=0 immediately (asynchronous); no out_valid after reset releases.

Source files
------------

// File: rtl/pe_pkg.sv
// pe_pkg: shared mode encodings, lane width and saturation bounds for the
// mixed-precision processing element.
package pe_pkg;
    localparam logic MODE_16B = 1'b0;
    localparam logic MODE_8B  = 1'b1;

    function automatic int lane_w(int w);
        return w / 2;
    endfunction

    function automatic logic [63:0] sat_max(int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(int w);
        return 64'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/pe_sat_add.sv
// pe_sat_add: signed W-bit adder with overflow detect and optional clamping
// to the signed W-bit range.
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int W      = 48,
    parameter bit SAT_EN = 1'b1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         ovf_o
);
    localparam logic [63:0] MAX = sat_max(W);
    localparam logic [63:0] MIN = sat_min(W);

    logic [W:0] s;

    assign s     = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    assign ovf_o = s[W] ^ s[W-1];
    assign sum_o = (SAT_EN && ovf_o) ? (s[W] ? MIN[W-1:0] : MAX[W-1:0]) : s[W-1:0];
endmodule

// File: rtl/pe_mp_acc.sv
// pe_mp_acc: two-stage precision-configurable MAC PE (one 16x16 or two packed
// 8-bit lanes per beat) with internal accumulation, saturation and sticky ovf.
module pe_mp_acc
    import pe_pkg::*;
#(
    parameter int ACT_WIDTH    = 16,
    parameter int WGT_WIDTH    = 16,
    parameter int PE_OUT_WIDTH = 48,
    parameter int LANES        = 2,
    parameter bit SAT_EN       = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    mode_8b,
    input  logic                    act_signed,
    input  logic [ACT_WIDTH-1:0]    a,
    input  logic [WGT_WIDTH-1:0]    b,
    input  logic [PE_OUT_WIDTH-1:0] c,
    input  logic                    c_sel,
    input  logic                    acc_clear,
    output logic [PE_OUT_WIDTH-1:0] out,
    output logic                    out_valid,
    output logic [1:0]              ovf
);
    localparam int LW  = lane_w(PE_OUT_WIDTH);
    localparam int PW  = ACT_WIDTH + WGT_WIDTH;
    localparam int LPW = 17;

    logic [PW-1:0]             p16_d, p16_q;
    logic [LANES-1:0][LPW-1:0] lp_d, lp_q;
    logic [LANES-1:0][LW-1:0]  lr;
    logic [LANES-1:0]          lo;
    logic                      v1_q, mode_q, c_sel_q, clr_q, o16, out_valid_q;
    logic [PE_OUT_WIDTH-1:0]   c_q, addend, r16, out_d, out_q;
    logic [1:0]                ovf_d, ovf_q;

    assign p16_d = $signed({{WGT_WIDTH{a[ACT_WIDTH-1]}}, a}) * $signed({{ACT_WIDTH{b[WGT_WIDTH-1]}}, b});

    // Feedback comes straight from out_q so back-to-back accumulation needs no bypass.
    assign addend = clr_q ? '0 : (c_sel_q ? c_q : out_q);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] ai;
        assign ai      = a[8*i +: 8];
        assign lp_d[i] = {{9{act_signed & ai[7]}}, ai} * {{9{b[7]}}, b[7:0]};
        pe_sat_add #(.W(LW), .SAT_EN(SAT_EN)) u_lane_add (
            .a_i   ({{(LW-LPW){lp_q[i][LPW-1]}}, lp_q[i]}),
            .b_i   (addend[LW*i +: LW]),
            .sum_o (lr[i]),
            .ovf_o (lo[i])
        );
    end

    pe_sat_add #(.W(PE_OUT_WIDTH), .SAT_EN(SAT_EN)) u_wide_add (
        .a_i   ({{(PE_OUT_WIDTH-PW){p16_q[PW-1]}}, p16_q}),
        .b_i   (addend),
        .sum_o (r16),
        .ovf_o (o16)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_q    <= 1'b0;
            mode_q  <= MODE_16B;
            c_sel_q <= 1'b0;
            clr_q   <= 1'b0;
            p16_q   <= '0;
            lp_q    <= '0;
            c_q     <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                mode_q  <= mode_8b;
                c_sel_q <= c_sel;
                clr_q   <= acc_clear;
                p16_q   <= p16_d;
                lp_q    <= lp_d;
                c_q     <= c;
            end
        end
    end

    always_comb begin
        out_d = out_q;
        ovf_d = ovf_q;
        if (v1_q) begin
            out_d = (mode_q == MODE_8B) ? lr : r16;
            ovf_d = (clr_q ? 2'b00 : ovf_q) | ((mode_q == MODE_16B) ? {1'b0, o16} : lo);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            ovf_q       <= 2'b00;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            ovf_q       <= ovf_d;
            out_valid_q <= v1_q;
        end
    end

    assign out       = out_q;
    assign ovf       = ovf_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_pe_mp_acc.sv
// tb_pe_mp_acc: scoreboard bench driving a saturating and a wrapping PE with
// the same beats and checking both against an integer reference model.
module tb_pe_mp_acc;
    typedef struct packed { logic [47:0] o; logic [1:0] f; } exp_t;

    logic        clk = 1'b0, reset = 1'b0, in_valid = 1'b0, mode_8b = 1'b0;
    logic        act_signed = 1'b0, c_sel = 1'b0, acc_clear = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [47:0] c = '0;
    logic [47:0] out_s, out_w;
    logic        ov_s, ov_w;
    logic [1:0]  f_s, f_w;

    int checks = 0, errors = 0;
    exp_t q_s[$], q_w[$];
    logic [47:0] acc_m [2] = '{48'd0, 48'd0};
    logic [1:0]  ovf_m [2] = '{2'b00, 2'b00};
    exp_t        last  [2] = '{'0, '0};
    logic        m_v;
    logic [47:0] m_o;
    logic [1:0]  m_f;
    exp_t        m_e;
    logic [47:0] cv;
    int          sel;

    always #5 clk = ~clk;

    pe_mp_acc #(.SAT_EN(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode_8b(mode_8b), .act_signed(act_signed),
        .a(a), .b(b), .c(c), .c_sel(c_sel), .acc_clear(acc_clear),
        .out(out_s), .out_valid(ov_s), .ovf(f_s)
    );

    pe_mp_acc #(.SAT_EN(1'b0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode_8b(mode_8b), .act_signed(act_signed),
        .a(a), .b(b), .c(c), .c_sel(c_sel), .acc_clear(acc_clear),
        .out(out_w), .out_valid(ov_w), .ovf(f_w)
    );

    // Reference: plain integer arithmetic with explicit range tests per lane.
    function automatic exp_t model(bit m8, bit sg, logic [15:0] av, logic [15:0] bv, logic [47:0] ad, bit sat);
        exp_t r;
        longint s, mx;
        int ls, ai;
        logic [63:0] u;
        logic [31:0] lu;
        r  = '0;
        mx = 64'sd140737488355327;
        if (!m8) begin
            s = longint'($signed(av)) * longint'($signed(bv)) + longint'($signed(ad));
            if (s > mx || s < -mx - 1) begin
                r.f[0] = 1'b1;
                if (sat) s = (s > 0) ? mx : -mx - 1;
            end
            u   = s;
            r.o = u[47:0];
        end else begin
            for (int i = 0; i < 2; i++) begin
                ai = sg ? int'($signed(av[8*i +: 8])) : int'(av[8*i +: 8]);
                ls = ai * int'($signed(bv[7:0])) + int'($signed(ad[24*i +: 24]));
                if (ls > 8388607 || ls < -8388608) begin
                    r.f[i] = 1'b1;
                    if (sat) ls = (ls > 0) ? 8388607 : -8388608;
                end
                lu = ls;
                r.o[24*i +: 24] = lu[23:0];
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, int k, logic [47:0] got, logic [47:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h want %h", nm, k, got, want);
        end
    endtask

    task automatic beat(bit v, bit m8, bit sg, logic [15:0] av, logic [15:0] bv, logic [47:0] cin, bit cs, bit clr);
        exp_t r;
        @(posedge clk);
        #1;
        in_valid = v; mode_8b = m8; act_signed = sg; a = av; b = bv; c = cin; c_sel = cs; acc_clear = clr;
        if (v) begin
            for (int k = 0; k < 2; k++) begin
                r = model(m8, sg, av, bv, clr ? 48'd0 : (cs ? cin : acc_m[k]), k == 0);
                ovf_m[k] = (clr ? 2'b00 : ovf_m[k]) | r.f;
                acc_m[k] = r.o;
                r.f = ovf_m[k];
                if (k == 0) q_s.push_back(r);
                else q_w.push_back(r);
            end
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++)
            beat(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), {16'($urandom), 32'($urandom)}, 1'($urandom), 1'($urandom));
    endtask

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m_v = (k == 0) ? ov_s : ov_w;
            m_o = (k == 0) ? out_s : out_w;
            m_f = (k == 0) ? f_s : f_w;
            if (m_v) begin
                if ((k == 0 && q_s.size() == 0) || (k == 1 && q_w.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid dut%0d got out=%h want no output", k, m_o);
                end else begin
                    if (k == 0) m_e = q_s.pop_front();
                    else m_e = q_w.pop_front();
                    chk("out", k, m_o, m_e.o);
                    chk("ovf", k, 48'(m_f), 48'(m_e.f));
                    last[k] = m_e;
                end
            end else begin
                chk("hold_out", k, m_o, last[k].o);
                chk("hold_ovf", k, 48'(m_f), 48'(last[k].f));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 0, out_s, 48'd0);
        chk("rst_valid", 0, 48'(ov_s), 48'd0);
        chk("rst_ovf", 1, 48'(f_w), 48'd0);
        reset = 1'b1;
        idle(1);
        beat(1, 0, 0, 16'h0003, 16'hFFFE, 48'd10, 1, 0);
        beat(1, 1, 0, 16'hFF02, 16'h0081, 48'd0, 1, 0);
        beat(1, 1, 1, 16'hFF02, 16'h0081, 48'd0, 1, 0);
        beat(1, 0, 0, 16'h0000, 16'h0000, 48'd0, 1, 1);
        beat(1, 1, 0, 16'h0101, 16'h0001, 48'h000005_7FFFFF, 1, 0);
        beat(1, 0, 0, 16'd100, 16'd3, 48'd0, 0, 1);
        beat(1, 0, 0, 16'd100, 16'd3, 48'd0, 0, 0);
        idle(2);
        beat(1, 0, 0, 16'd100, 16'd3, 48'd0, 0, 0);
        beat(1, 0, 0, 16'd100, 16'd3, 48'd0, 0, 0);
        beat(1, 0, 0, 16'h0102, 16'd2, 48'd0, 1, 0);
        beat(1, 1, 0, 16'h0102, 16'd2, 48'd0, 1, 0);
        beat(1, 0, 0, 16'd1, 16'd1, 48'h7FFF_FFFF_FFFF, 1, 0);
        beat(1, 0, 0, 16'd0, 16'd0, 48'd77, 1, 0);
        idle(4);
        beat(1, 0, 0, 16'd5, 16'd5, 48'd0, 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        chk("pre_rst_out", 0, out_s, 48'd77);
        chk("pre_rst_ovf", 1, 48'(f_w), 48'd1);
        reset = 1'b0;
        #1;
        chk("async_rst_out", 0, out_s, 48'd0);
        chk("async_rst_valid", 0, 48'(ov_s), 48'd0);
        chk("async_rst_ovf", 0, 48'(f_s), 48'd0);
        chk("async_rst_ovf", 1, 48'(f_w), 48'd0);
        q_s.delete();
        q_w.delete();
        acc_m = '{48'd0, 48'd0};
        ovf_m = '{2'b00, 2'b00};
        last  = '{'0, '0};
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(5);
        for (int n = 0; n < 1500; n++) begin
            sel = $urandom_range(3);
            cv  = {16'($urandom), 32'($urandom)};
            if (sel == 0) cv = {24'h7FFFFF - 24'($urandom_range(300)), 24'h800000 + 24'($urandom_range(300))};
            else if (sel == 1) cv = 48'h7FFF_FFFF_FFFF - 48'($urandom >> 1);
            else if (sel == 2) cv = 48'h8000_0000_0000 + 48'($urandom >> 1);
            beat($urandom_range(3) != 0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), cv,
                 1'($urandom), $urandom_range(9) == 0);
        end
        idle(1);
        for (int n = 0; n < 20 && (q_s.size() != 0 || q_w.size() != 0); n++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q_s.size() != 0 || q_w.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d/%0d want 0/0", q_s.size(), q_w.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
